// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB565 colour constants and pixel-request sentinel.
// Imported by vga_ctrl, vga_raster_cnt and the vga_pic pixel source.
package vga_pkg;

   localparam int H_SYNC_DEF  = 96;
   localparam int H_BACK_DEF  = 48;
   localparam int H_VALID_DEF = 640;
   localparam int H_FRONT_DEF = 16;
   localparam int V_SYNC_DEF  = 2;
   localparam int V_BACK_DEF  = 33;
   localparam int V_VALID_DEF = 480;
   localparam int V_FRONT_DEF = 10;

   localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
   localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;
   localparam int H_START = H_SYNC_DEF + H_BACK_DEF;
   localparam int V_START = V_SYNC_DEF + V_BACK_DEF;

   typedef logic [15:0] rgb565_t;

   localparam rgb565_t RED    = 16'hF800;
   localparam rgb565_t ORANGE = 16'hFC00;
   localparam rgb565_t YELLOW = 16'hFFE0;
   localparam rgb565_t GREEN  = 16'h07E0;
   localparam rgb565_t CYAN   = 16'h07FF;
   localparam rgb565_t BLUE   = 16'h001F;
   localparam rgb565_t PURPLE = 16'hF81F;
   localparam rgb565_t BLACK  = 16'h0000;
   localparam rgb565_t WHITE  = 16'hFFFF;
   localparam rgb565_t GRAY   = 16'hD69A;

   localparam logic [9:0] PIX_INVALID = 10'h3FF;

   typedef enum logic [3:0] {
      BAR_RED, BAR_ORANGE, BAR_YELLOW, BAR_GREEN, BAR_CYAN,
      BAR_BLUE, BAR_PURPLE, BAR_BLACK, BAR_WHITE, BAR_GRAY
   } bar_e;

   // Colour of each 64-pixel-wide bar of the default test pattern.
   function automatic rgb565_t bar_colour(input bar_e bar);
      case (bar)
         BAR_RED:    return RED;
         BAR_ORANGE: return ORANGE;
         BAR_YELLOW: return YELLOW;
         BAR_GREEN:  return GREEN;
         BAR_CYAN:   return CYAN;
         BAR_BLUE:   return BLUE;
         BAR_PURPLE: return PURPLE;
         BAR_BLACK:  return BLACK;
         BAR_WHITE:  return WHITE;
         default:    return GRAY;
      endcase
   endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with line and frame wrap strobes.
// Optional VGA_CTRL_FRAME_CNT_EN adds the frame_start pulse and frame counter.
module vga_raster_cnt
   import vga_pkg::*;
#(
   parameter int H_TOTAL_P = H_TOTAL,
   parameter int V_TOTAL_P = V_TOTAL
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   output logic [9:0]  cnt_h_o,
   output logic [9:0]  cnt_v_o
`ifdef VGA_CTRL_FRAME_CNT_EN
   ,
   output logic        frame_start_o,
   output logic [15:0] frame_cnt_o
`endif
);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL_P - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL_P - 1);

   logic [9:0] cnt_h_q, cnt_h_d;
   logic [9:0] cnt_v_q, cnt_v_d;
   logic       line_end;
   logic       frame_end;

   always_comb begin
      line_end  = (cnt_h_q == H_LAST);
      frame_end = line_end && (cnt_v_q == V_LAST);
      cnt_h_d   = line_end ? '0 : cnt_h_q + 10'd1;
      cnt_v_d   = cnt_v_q;
      if (line_end) begin
         cnt_v_d = frame_end ? '0 : cnt_v_q + 10'd1;
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_h_q <= '0;
         cnt_v_q <= '0;
      end else begin
         cnt_h_q <= cnt_h_d;
         cnt_v_q <= cnt_v_d;
      end
   end

   assign cnt_h_o = cnt_h_q;
   assign cnt_v_o = cnt_v_q;

`ifdef VGA_CTRL_FRAME_CNT_EN
   // Registering the wrap strobe yields a pulse at (0,0) that reset can never fake.
   logic        wrap_q;
   logic [15:0] frame_cnt_q;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wrap_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         wrap_q <= frame_end;
         if (wrap_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign frame_start_o = wrap_q;
   assign frame_cnt_o   = frame_cnt_q;
`endif

endmodule

// File: rtl/vga_ctrl.sv
// VGA raster timing controller: sync generation, early pixel requests, rgb capture.
// Optional VGA_CTRL_FRAME_CNT_EN adds frame_start / frame_cnt outputs.
module vga_ctrl
   import vga_pkg::*;
#(
   parameter int H_SYNC  = H_SYNC_DEF,
   parameter int H_BACK  = H_BACK_DEF,
   parameter int H_VALID = H_VALID_DEF,
   parameter int H_FRONT = H_FRONT_DEF,
   parameter int V_SYNC  = V_SYNC_DEF,
   parameter int V_BACK  = V_BACK_DEF,
   parameter int V_VALID = V_VALID_DEF,
   parameter int V_FRONT = V_FRONT_DEF,
   parameter int PIX_LAT = 1
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic [15:0] rgb,
   output logic        rgb_valid
`ifdef VGA_CTRL_FRAME_CNT_EN
   ,
   output logic        frame_start,
   output logic [15:0] frame_cnt
`endif
);

   localparam int HT = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int VT = V_SYNC + V_BACK + V_VALID + V_FRONT;

   localparam logic [9:0] HS_END = 10'(H_SYNC);
   localparam logic [9:0] VS_END = 10'(V_SYNC);
   localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_HI   = 10'(H_SYNC + H_BACK + H_VALID);
   localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_HI   = 10'(V_SYNC + V_BACK + V_VALID);
   localparam logic [9:0] REQ_LO = 10'(H_SYNC + H_BACK - PIX_LAT);
   localparam logic [9:0] REQ_HI = 10'(H_SYNC + H_BACK + H_VALID - PIX_LAT);

   logic [9:0] cnt_h;
   logic [9:0] cnt_v;
   logic       line_act;
   logic       req_act;

   vga_raster_cnt #(
      .H_TOTAL_P (HT),
      .V_TOTAL_P (VT)
   ) u_raster (
      .vga_clk       (vga_clk),
      .sys_rst_n     (sys_rst_n),
      .cnt_h_o       (cnt_h),
      .cnt_v_o       (cnt_v)
`ifdef VGA_CTRL_FRAME_CNT_EN
      ,
      .frame_start_o (frame_start),
      .frame_cnt_o   (frame_cnt)
`endif
   );

   // Requests run PIX_LAT clocks ahead so registered pixel data lands on rgb_valid.
   always_comb begin
      hsync     = (cnt_h >= HS_END);
      vsync     = (cnt_v >= VS_END);
      line_act  = (cnt_v >= V_LO) && (cnt_v < V_HI);
      rgb_valid = line_act && (cnt_h >= H_LO) && (cnt_h < H_HI);
      req_act   = line_act && (cnt_h >= REQ_LO) && (cnt_h < REQ_HI);
      pix_x     = req_act ? cnt_h - REQ_LO : PIX_INVALID;
      pix_y     = req_act ? cnt_v - V_LO   : PIX_INVALID;
      rgb       = rgb_valid ? pix_data : '0;
   end

endmodule
